// File: rtl/deriv_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output derivative ROM among lanes.
// Tags follow the ROM read latency so each result returns to its requester.
module deriv_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant;
    logic             s1_valid;
    logic [IDX_W-1:0] s1_tag;

    // Search upward from the lane after the last winner, wrapping once around.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        if (en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!grant && req_valid[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant) req_ready[grant_idx] = 1'b1;
    end

    assign rom_addr = grant ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDX_W'(NUM_REQ - 1);
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (grant) ptr <= grant_idx;
            s1_valid <= grant;
            s1_tag   <= grant_idx;
        end
    end

    // rom_dout in this cycle belongs to s1_tag; register it out with a one-hot strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (s1_valid) begin
                rsp_valid[s1_tag] <= 1'b1;
                rsp_data          <= rom_dout;
            end
        end
    end

    assign busy = s1_valid | (|rsp_valid);

endmodule

// File: doc/deriv_rom_arbiter.md
# deriv_rom_arbiter

Round-robin arbiter that shares one registered-output derivative ROM (8-bit address, 9-bit two's-complement data, one-cycle read latency) among several weight-update lanes of the SNN forward-forward learning engine. It accepts one lookup per cycle from the winning lane, drives the ROM address, tracks the requester tag through the ROM read pipeline, and returns the result to the originating lane with a one-hot valid. It sits between the per-lane update units and a single ROM instance, which is external to this block.

## Interface
- NUM_REQ, 4, number of requesting lanes (2..16)
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 9, ROM data width (two's complement)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; 0 blocks new grants, in-flight lookups still complete
- req_valid  in  NUM_REQ  per-lane lookup request
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-lane address, lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant, combinational; lookup accepted when req_valid[i] & req_ready[i]
- rom_addr  out  ADDR_WIDTH  address to the ROM, combinational from the granted lane
- rom_dout  in  DATA_WIDTH  ROM registered output
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_WIDTH  response data, registered, valid only while any rsp_valid bit is set
- busy  out  1  1 while any lookup is in flight (stage 1 or stage 2 valid)

## Operation
- Grant: when en=1 and req_valid nonzero, grant exactly one lane: first set req_valid bit searching upward from (ptr+1) mod NUM_REQ, wrapping. req_ready all-zero when en=0 or no request.
- ptr: registered index of last granted lane; updates to granted index only on a grant; holds otherwise. Reset value NUM_REQ-1, so lane 0 has first priority after reset.
- rom_addr = req_addr of granted lane; all-zero when no grant.
- Stage 1 registers (s1_valid, s1_tag): on each edge, s1_valid <= grant occurred, s1_tag <= granted index. Matches ROM read latency; rom_dout in the cycle after the grant belongs to s1_tag.
- Stage 2 (output): rsp_valid <= s1_valid ? one-hot(s1_tag) : 0; rsp_data <= rom_dout when s1_valid, else holds previous value.
- No response backpressure: lanes must consume rsp_data in the cycle rsp_valid is high.
- A lane may hold req_valid high continuously; it is re-granted only after all other requesting lanes have been served once (fairness bound: at most NUM_REQ-1 cycles wait).
- req_addr may change while not granted; only the value present in the grant cycle is used.
- en deasserted mid-stream: no new grants from that cycle; already-granted lookups produce responses normally; ptr holds.
- Reset (async, any time): s1_valid=0, rsp_valid=0, rsp_data=0, ptr=NUM_REQ-1, busy=0; in-flight lookups are discarded with no response. Combinational outputs follow inputs immediately after reset deassertion.

## Timing
- Throughput: one lookup per cycle, sustained, across any mix of lanes.
- Latency: grant in cycle T (rom_addr driven in T), rom_dout valid in T+1, rsp_valid/rsp_data in T+2.
- req_ready and rom_addr are combinational from req_valid, req_addr, en, ptr; no combinational path from rom_dout to any output.
- busy = s1_valid | (|rsp_valid), registered-source only.
- Simultaneous grant and response for the same lane in one cycle is legal and independent.

## Test plan
- Single request: after reset, lane 2 req_valid=1, addr=8'd255 for one cycle -> req_ready=4'b0100 in T, rom_addr=8'hFF in T, rsp_valid=4'b0100 and rsp_data=9'h1F0 in T+2, busy high T+1..T+2.
- Round-robin: all four lanes requesting continuously with distinct addresses -> grants 0,1,2,3,0,1,... one per cycle; each rsp_data matches that lane's address lookup, tag order preserved.
- Fairness after skip: ptr=1, lanes 0 and 3 requesting -> lane 3 granted first, then lane 0.
- Enable gating: requests pending, en dropped in cycle T -> no req_ready from T; the grant of T-1 still yields rsp_valid in T+1; busy falls afterwards; re-raising en resumes from ptr+1.
- Reset mid-flight: assert rst_n=0 one cycle after a grant -> rsp_valid stays 0, no response emerges after reset release, first post-reset grant goes to lane 0.
- Idle: req_valid=0 -> req_ready=0, rom_addr=0, rsp_valid=0, rsp_data holds last value, ptr unchanged.
